// File: rtl/grid_io_pkg.sv
// rtl/grid_io_pkg.sv - shared constants and state encoding for the GPIO bank
package grid_io_pkg;

   localparam int CFG_W    = 3;
   localparam int CFG_DIR  = 0;
   localparam int CFG_SYNC = 1;
   localparam int CFG_INV  = 2;

   typedef enum logic [1:0] {
      UNCFG   = 2'd0,
      LOADING = 2'd1,
      ACTIVE  = 2'd2
   } cfg_state_t;

endpackage

// File: rtl/grid_io_chan.sv
// rtl/grid_io_chan.sv - one GPIO channel: direction, inversion and optional 2-flop input sync
module grid_io_chan
   import grid_io_pkg::*;
(
   input  logic             prog_clk,
   input  logic             pReset_n,
   input  logic [CFG_W-1:0] cfg,
   input  logic             cfg_live,
   input  logic             outpad,
   input  logic             pad_in,
   output logic             inpad,
   output logic             pad_out,
   output logic             pad_oe
);

   logic s1;
   logic s2;

   // Synchroniser runs unconditionally so a sync enable sees settled data at once.
   always_ff @(posedge prog_clk) begin
      if (!pReset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pad_in;
         s2 <= s1;
      end
   end

   assign pad_oe  = cfg[CFG_DIR] & cfg_live;
   assign pad_out = outpad ^ cfg[CFG_INV];
   assign inpad   = cfg[CFG_DIR] ? 1'b0
                                 : ((cfg[CFG_SYNC] ? s2 : pad_in) ^ cfg[CFG_INV]);

endmodule

// File: rtl/grid_io_bank.sv
// rtl/grid_io_bank.sv - GPIO bank with serial config chain, commit check and per-channel data paths
module grid_io_bank
   import grid_io_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              ccff_head,
   input  logic              ccff_en,
   input  logic              cfg_commit,
   output logic              ccff_tail,
   output logic              cfg_ok,
   output logic              cfg_err,
   input  logic [NUM_CH-1:0] outpad,
   output logic [NUM_CH-1:0] inpad,
   input  logic [NUM_CH-1:0] gfpga_pad_GPIO_PAD_in,
   output logic [NUM_CH-1:0] gfpga_pad_GPIO_PAD_out,
   output logic [NUM_CH-1:0] gfpga_pad_GPIO_PAD_oe
);

   localparam int CHAIN_LEN = NUM_CH * CFG_W;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0] sr;
   logic [CHAIN_LEN-1:0] active_cfg;
   logic [CNT_W-1:0]     count;
   logic                 cfg_valid;
   cfg_state_t           state;
   cfg_state_t           state_nxt;

   logic shift_en;
   logic commit_good;

   // A commit in the same cycle as a shift wins; the shift is dropped.
   assign shift_en    = ccff_en && !cfg_commit;
   assign commit_good = cfg_commit && (count == CNT_FULL);
   assign ccff_tail   = sr[CHAIN_LEN-1];

   always_ff @(posedge prog_clk) begin
      if (!pReset_n) begin
         sr         <= '0;
         active_cfg <= '0;
         count      <= '0;
         cfg_valid  <= 1'b0;
         cfg_ok     <= 1'b0;
         cfg_err    <= 1'b0;
         state      <= UNCFG;
      end else begin
         state <= state_nxt;
         if (shift_en) begin
            sr <= {sr[CHAIN_LEN-2:0], ccff_head};
            if (count != CNT_SAT) begin
               count <= count + 1'b1;
            end
         end
         if (cfg_commit) begin
            count   <= '0;
            cfg_ok  <= commit_good;
            cfg_err <= !commit_good;
            if (commit_good) begin
               active_cfg <= sr;
               cfg_valid  <= 1'b1;
            end
         end
      end
   end

   // A bad commit only falls back to UNCFG if nothing was ever applied.
   always_comb begin
      state_nxt = state;
      unique case (state)
         UNCFG: begin
            if (cfg_commit) begin
               state_nxt = commit_good ? ACTIVE : UNCFG;
            end else if (ccff_en) begin
               state_nxt = LOADING;
            end
         end
         LOADING: begin
            if (cfg_commit) begin
               state_nxt = (commit_good || cfg_valid) ? ACTIVE : UNCFG;
            end
         end
         ACTIVE: begin
            if (cfg_commit) begin
               state_nxt = ACTIVE;
            end else if (ccff_en) begin
               state_nxt = LOADING;
            end
         end
         default: state_nxt = UNCFG;
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      grid_io_chan u_chan (
         .prog_clk (prog_clk),
         .pReset_n (pReset_n),
         .cfg      (active_cfg[CFG_W*i +: CFG_W]),
         .cfg_live (state != UNCFG),
         .outpad   (outpad[i]),
         .pad_in   (gfpga_pad_GPIO_PAD_in[i]),
         .inpad    (inpad[i]),
         .pad_out  (gfpga_pad_GPIO_PAD_out[i]),
         .pad_oe   (gfpga_pad_GPIO_PAD_oe[i])
      );
   end

endmodule

// File: tb/tb_grid_io_bank.sv
// tb/tb_grid_io_bank.sv - directed vector bench for grid_io_bank with NUM_CH=4
module tb_grid_io_bank;
   import grid_io_pkg::*;

   logic       prog_clk;
   logic       pReset_n;
   logic       ccff_head;
   logic       ccff_en;
   logic       cfg_commit;
   logic       ccff_tail;
   logic       cfg_ok;
   logic       cfg_err;
   logic [3:0] outpad;
   logic [3:0] inpad;
   logic [3:0] pad_in;
   logic [3:0] pad_out;
   logic [3:0] pad_oe;

   int checks;
   int failures;

   grid_io_bank #(.NUM_CH(4)) dut (
      .prog_clk               (prog_clk),
      .pReset_n               (pReset_n),
      .ccff_head              (ccff_head),
      .ccff_en                (ccff_en),
      .cfg_commit             (cfg_commit),
      .ccff_tail              (ccff_tail),
      .cfg_ok                 (cfg_ok),
      .cfg_err                (cfg_err),
      .outpad                 (outpad),
      .inpad                  (inpad),
      .gfpga_pad_GPIO_PAD_in  (pad_in),
      .gfpga_pad_GPIO_PAD_out (pad_out),
      .gfpga_pad_GPIO_PAD_oe  (pad_oe)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   typedef struct {
      logic [11:0] cfg;
      logic [3:0]  outpad;
      logic [3:0]  pad_in;
      logic [3:0]  exp_oe;
      logic [3:0]  exp_out;
      logic [3:0]  exp_inpad;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic shift_bits(input logic [11:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ccff_en   = 1'b1;
         ccff_head = w[i];
         tick();
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] pat;
      checks     = 0;
      failures   = 0;
      pReset_n   = 1'b0;
      ccff_head  = 1'b0;
      ccff_en    = 1'b0;
      cfg_commit = 1'b0;
      outpad     = 4'b0110;
      pad_in     = 4'b1010;

      //               cfg      outpad   pad_in   oe       out      inpad
      vecs[0] = '{12'h111, 4'b0101, 4'b1010, 4'b0001, 4'b0001, 4'b1110};
      vecs[1] = '{12'h249, 4'b1100, 4'b0110, 4'b1111, 4'b1100, 4'b0000};
      vecs[2] = '{12'h924, 4'b0011, 4'b0101, 4'b0000, 4'b1100, 4'b1010};
      vecs[3] = '{12'h4F5, 4'b1111, 4'b1111, 4'b0101, 4'b1100, 4'b1000};
      vecs[4] = '{12'h000, 4'b1001, 4'b0011, 4'b0000, 4'b1001, 4'b0011};

      tick();
      tick();
      chk("reset_oe", 32'(pad_oe), 32'h0);
      chk("reset_out", 32'(pad_out), 32'h6);
      chk("reset_inpad", 32'(inpad), 32'hA);
      chk("reset_tail", 32'(ccff_tail), 32'h0);
      chk("reset_ok", 32'(cfg_ok), 32'h0);
      chk("reset_err", 32'(cfg_err), 32'h0);
      chk("reset_state", 32'(dut.state), 32'(UNCFG));
      pReset_n = 1'b1;
      tick();

      // first load is short: must fall back to UNCFG
      shift_bits(12'h111, 11);
      commit();
      chk("first_bad_err", 32'(cfg_err), 32'h1);
      chk("first_bad_ok", 32'(cfg_ok), 32'h0);
      chk("first_bad_oe", 32'(pad_oe), 32'h0);
      chk("first_bad_state", 32'(dut.state), 32'(UNCFG));

      shift_bits(12'h111, 12);
      commit();
      chk("good_ok", 32'(cfg_ok), 32'h1);
      chk("good_err", 32'(cfg_err), 32'h0);
      chk("good_oe", 32'(pad_oe), 32'h1);
      chk("good_state", 32'(dut.state), 32'(ACTIVE));

      pad_in = 4'b0000;
      tick(); tick(); tick();
      pad_in = 4'b0010;
      #1;
      chk("sync_lat0", 32'(inpad[1]), 32'h0);
      chk("inv_ch2_lo", 32'(inpad[2]), 32'h1);
      tick();
      chk("sync_lat1", 32'(inpad[1]), 32'h0);
      tick();
      chk("sync_lat2", 32'(inpad[1]), 32'h1);
      pad_in = 4'b0110;
      #1;
      chk("inv_ch2_hi", 32'(inpad[2]), 32'h0);

      // short load while active keeps the old configuration throughout
      shift_bits(12'h249, 11);
      chk("loading_oe", 32'(pad_oe), 32'h1);
      chk("loading_state", 32'(dut.state), 32'(LOADING));
      commit();
      chk("act_bad_err", 32'(cfg_err), 32'h1);
      chk("act_bad_ok", 32'(cfg_ok), 32'h0);
      chk("act_bad_oe", 32'(pad_oe), 32'h1);
      chk("act_bad_state", 32'(dut.state), 32'(ACTIVE));

      for (int v = 0; v < 5; v++) begin
         shift_bits(vecs[v].cfg, 12);
         commit();
         outpad = vecs[v].outpad;
         pad_in = vecs[v].pad_in;
         tick(); tick(); tick();
         chk($sformatf("vec%0d_ok", v), 32'(cfg_ok), 32'h1);
         chk($sformatf("vec%0d_oe", v), 32'(pad_oe), 32'(vecs[v].exp_oe));
         chk($sformatf("vec%0d_out", v), 32'(pad_out), 32'(vecs[v].exp_out));
         chk($sformatf("vec%0d_inpad", v), 32'(inpad), 32'(vecs[v].exp_inpad));
      end

      pat = 24'hA5C3F1;
      for (int j = 0; j < 24; j++) begin
         ccff_en   = 1'b1;
         ccff_head = pat[j];
         tick();
         if (j + 1 >= 12 && j + 1 < 24) begin
            chk($sformatf("stream_tail%0d", j + 1), 32'(ccff_tail), 32'(pat[j + 1 - 12]));
         end
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
      chk("count_sat", 32'(dut.count), 32'd13);
      commit();
      chk("over_err", 32'(cfg_err), 32'h1);
      chk("over_oe", 32'(pad_oe), 32'h0);
      chk("over_state", 32'(dut.state), 32'(ACTIVE));

      shift_bits(12'h249, 12);
      ccff_en    = 1'b1;
      ccff_head  = 1'b1;
      cfg_commit = 1'b1;
      tick();
      ccff_en    = 1'b0;
      ccff_head  = 1'b0;
      cfg_commit = 1'b0;
      chk("both_ok", 32'(cfg_ok), 32'h1);
      chk("both_oe", 32'(pad_oe), 32'hF);
      chk("both_sr", 32'(dut.sr), 32'h249);
      chk("both_count", 32'(dut.count), 32'h0);
      chk("both_tail", 32'(ccff_tail), 32'h0);

      // reset mid-shift overrides shift and commit in the same cycle
      shift_bits(12'hFFF, 6);
      outpad     = 4'b1011;
      pad_in     = 4'b0101;
      pReset_n   = 1'b0;
      ccff_en    = 1'b1;
      cfg_commit = 1'b1;
      tick();
      ccff_en    = 1'b0;
      cfg_commit = 1'b0;
      chk("rst2_oe", 32'(pad_oe), 32'h0);
      chk("rst2_out", 32'(pad_out), 32'hB);
      chk("rst2_inpad", 32'(inpad), 32'h5);
      chk("rst2_tail", 32'(ccff_tail), 32'h0);
      chk("rst2_ok", 32'(cfg_ok), 32'h0);
      chk("rst2_err", 32'(cfg_err), 32'h0);
      chk("rst2_count", 32'(dut.count), 32'h0);
      chk("rst2_sr", 32'(dut.sr), 32'h0);
      chk("rst2_state", 32'(dut.state), 32'(UNCFG));
      pReset_n = 1'b1;
      tick();
      shift_bits(12'h249, 12);
      commit();
      chk("reload_ok", 32'(cfg_ok), 32'h1);
      chk("reload_oe", 32'(pad_oe), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
